// File: rtl/a_tx_packet_arbiter_pkg.sv
// Shared constants for the Alice TX packet arbiter: FSM state encodings,
// producer index map and the default watchdog limit.
package a_tx_packet_arbiter_pkg;

    typedef logic [2:0] arb_state_t;

    // FSM state encodings, also exported on A_tx_arb_state for debug
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GRANT      = 3'd1;
    localparam logic [2:0] ST_WAIT_WRITE = 3'd2;
    localparam logic [2:0] ST_NOTIFY     = 3'd3;
    localparam logic [2:0] ST_WAIT_SEND  = 3'd4;
    localparam logic [2:0] ST_RELEASE    = 3'd5;

    // Producer slots on the req/wr_done/grant vectors
    localparam int REQ_SIFT      = 0;
    localparam int REQ_ER_PARITY = 1;
    localparam int REQ_HASHTAG   = 2;
    localparam int REQ_PA        = 3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // PP side holds the TX BRAM from grant until the network finished sending
    function automatic logic is_pp_owned(input arb_state_t s);
        return (s == ST_GRANT) || (s == ST_WAIT_WRITE) ||
               (s == ST_NOTIFY) || (s == ST_WAIT_SEND);
    endfunction

    // States in which the arbiter waits on someone else and may hang
    function automatic logic is_timed_state(input arb_state_t s);
        return (s == ST_WAIT_WRITE) || (s == ST_NOTIFY) || (s == ST_WAIT_SEND);
    endfunction

endpackage

// File: rtl/a_tx_packet_arbiter_fsm.sv
// Packet-lifecycle FSM of the TX arbiter: grant, wait for the producer to
// finish writing, hand the packet to the network, then release.
module a_tx_arb_fsm
    import a_tx_packet_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_any,
    input  logic       win_done,
    input  logic       net_busy,
    input  logic       force_release,
    output logic [2:0] state_q,
    output logic [2:0] state_d,
    output logic       busy_pp2net,
    output logic       msg_stored
);

    // Next-state: one packet at a time; watchdog can cut any waiting state short
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (req_any)   state_d = ST_GRANT;
            ST_GRANT:                     state_d = ST_WAIT_WRITE;
            ST_WAIT_WRITE: if (win_done)  state_d = ST_NOTIFY;
            ST_NOTIFY:     if (net_busy)  state_d = ST_WAIT_SEND;
            ST_WAIT_SEND:  if (!net_busy) state_d = ST_RELEASE;
            ST_RELEASE:                   state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
        if (force_release && is_timed_state(state_q)) begin
            state_d = ST_RELEASE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs decode straight from the state flops (glitch-free)
    always_comb begin
        busy_pp2net = is_pp_owned(state_q);
        msg_stored  = (state_q == ST_NOTIFY);
    end

endmodule

// File: rtl/a_tx_packet_arbiter.sv
// Round-robin arbiter sharing Alice's TX packet BRAM and network TX port
// among the post-processing producers. Holds the round-robin pick, rr_ptr,
// the grant register and the optional watchdog.
// Optional feature: define A_TX_ARB_TIMEOUT_EN to build the watchdog.
module a_tx_packet_arbiter
    import a_tx_packet_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] wr_done,
    output logic [NUM_REQ-1:0] grant,
    input  logic               busy_Net2PP_TX,
    output logic               msg_stored,
    output logic               busy_PP2Net_TX,
    output logic               arb_timeout,
    output logic [2:0]         A_tx_arb_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         state_q, state_d;
    logic               timeout_hit;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int cand;
        logic [PTR_W-1:0] cand_w;
        cand       = 0;
        cand_w     = '0;
        pick_idx   = rr_ptr_q;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand   = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand_w = PTR_W'(cand);
            if (!pick_found && req[cand_w]) begin
                pick_found = 1'b1;
                pick_idx   = cand_w;
            end
        end
    end

    a_tx_arb_fsm u_fsm (
        .clk           (clk),
        .rst           (rst),
        .req_any       (|req),
        .win_done      (wr_done[winner_q]),
        .net_busy      (busy_Net2PP_TX),
        .force_release (timeout_hit),
        .state_q       (state_q),
        .state_d       (state_d),
        .busy_pp2net   (busy_PP2Net_TX),
        .msg_stored    (msg_stored)
    );

    // Winner latched when leaving IDLE; pointer moves past it on RELEASE
    always_comb begin
        winner_d = winner_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE && pick_found) begin
            winner_d = pick_idx;
        end
        if (state_q == ST_RELEASE) begin
            rr_ptr_d = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + PTR_W'(1);
        end
    end

    // Grant is owned exactly while the FSM sits in WAIT_WRITE, so it can
    // never overlap msg_stored and drops on any forced release
    always_comb begin
        grant_d = '0;
        if (state_d == ST_WAIT_WRITE) begin
            grant_d = NUM_REQ'(1) << winner_q;
        end
    end

    // Arbitration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            winner_q <= '0;
            grant_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
        end
    end

`ifdef A_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             arb_timeout_q, arb_timeout_d;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in one waiting state
    assign timeout_hit = is_timed_state(state_q) &&
                         (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Dwell counter restarts on every state change; flag is sticky until reset
    always_comb begin
        wd_cnt_d      = '0;
        arb_timeout_d = arb_timeout_q | timeout_hit;
        if (state_d == state_q && is_timed_state(state_q)) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            arb_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            arb_timeout_q <= arb_timeout_d;
        end
    end

    assign arb_timeout = arb_timeout_q;
`else
    // Limit has no meaning without the watchdog; the FSM waits indefinitely
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    assign grant          = grant_q;
    assign A_tx_arb_state = state_q;

endmodule

// File: tb/tb_a_tx_packet_arbiter.sv
// Self-checking bench for a_tx_packet_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Watchdog checks follow A_TX_ARB_TIMEOUT_EN when it is defined.
module tb_a_tx_packet_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] wr_done = 4'b0;
    logic       busy_net = 1'b0;
    logic [3:0] grant;
    logic       msg_stored;
    logic       busy_pp;
    logic       arb_timeout;
    logic [2:0] st;

    a_tx_packet_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .wr_done        (wr_done),
        .grant          (grant),
        .busy_Net2PP_TX (busy_net),
        .msg_stored     (msg_stored),
        .busy_PP2Net_TX (busy_pp),
        .arb_timeout    (arb_timeout),
        .A_tx_arb_state (st)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 grant, 2 producer writing, 3 notify net,
    // 4 net sending, 5 release
    logic       s_rst, s_busy;
    logic [3:0] s_req, s_wd;
    int         m_ph = 0, m_ptr = 0, m_own = 0, m_dwell = 0;
    bit         m_tflag = 1'b0;

    always @(posedge clk) begin
        s_rst  <= rst;
        s_req  <= req;
        s_wd   <= wr_done;
        s_busy <= busy_net;
    end

    function automatic int rr_pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return ptr;
    endfunction

    initial begin
        logic [3:0] one;
        logic [3:0] exp_grant;
        int nxt;
        one = 4'b0001;
        forever begin
            @(negedge clk);
            if (s_rst) begin
                m_ph = 0; m_ptr = 0; m_own = 0; m_dwell = 0; m_tflag = 1'b0;
            end else begin
                case (m_ph)
                    0: if (s_req != 4'b0) begin m_own = rr_pick(s_req, m_ptr); m_ph = 1; end
                    1: begin m_ph = 2; m_dwell = 0; end
                    2, 3, 4: begin
                        nxt = m_ph;
                        if (m_ph == 2 && s_wd[m_own]) nxt = 3;
                        if (m_ph == 3 && s_busy)      nxt = 4;
                        if (m_ph == 4 && !s_busy)     nxt = 5;
`ifdef A_TX_ARB_TIMEOUT_EN
                        m_dwell++;
                        if (m_dwell >= TO) begin nxt = 5; m_tflag = 1'b1; end
`endif
                        if (nxt != m_ph) m_dwell = 0;
                        m_ph = nxt;
                    end
                    5: begin m_ptr = (m_own + 1) % N; m_ph = 0; end
                    default: m_ph = 0;
                endcase
            end
            if (chk_en) begin
                exp_grant = (m_ph == 2) ? (one << m_own) : 4'b0;
                check("model_grant", grant, exp_grant);
                check("model_msg_stored", msg_stored, (m_ph == 3));
                check("model_busy_pp", busy_pp, (m_ph >= 1 && m_ph <= 4));
                check("model_state", st, m_ph);
                check("model_timeout", arb_timeout, m_tflag);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_grant(output logic [3:0] g, inout int cyc);
        while (grant == 4'b0 && cyc < 30) begin step(); cyc++; end
        if (grant == 4'b0) check("grant_wait_bound", {28'b0, grant}, 32'hF);
        g = grant;
    endtask

    task automatic finish_send(input int busy_len, inout int cyc);
        int guard;
        busy_net = 1'b1;
        repeat (busy_len) begin step(); cyc++; end
        busy_net = 1'b0;
        guard = 0;
        while (st != 3'd0 && guard < 30) begin step(); cyc++; guard++; end
        if (st != 3'd0) check("idle_wait_bound", st, 0);
    endtask

    task automatic run_packet(input logic [3:0] r, input int busy_len,
                              output logic [3:0] g, output int cyc);
        cyc = 0;
        req = r;
        wait_grant(g, cyc);
        wr_done = g;
        step(); cyc++;
        wr_done = 4'b0;
        finish_send(busy_len, cyc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] g;
        logic [3:0] fair_tab [8];
        int c;
        int k;
        fair_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000};

        repeat (3) step();
        chk_en = 1'b1;
        check("rst_grant", grant, 0);
        check("rst_msg", msg_stored, 0);
        check("rst_busy", busy_pp, 0);
        check("rst_timeout", arb_timeout, 0);
        check("rst_state", st, 0);
        rst = 1'b0;

        // single request on slot 2
        req = 4'b0100;
        step();
        check("single_state_grant", st, 1);
        check("single_grant_not_yet", grant, 0);
        step();
        check("single_grant", grant, 4'b0100);
        req = 4'b0;
        wr_done = 4'b0100;
        step();
        wr_done = 4'b0;
        check("single_msg", msg_stored, 1);
        check("single_grant_clear", grant, 0);
        busy_net = 1'b1;
        repeat (3) step();
        busy_net = 1'b0;
        step();
        check("single_release", st, 5);
        check("single_release_busy", busy_pp, 0);
        step();
        check("single_idle", st, 0);

        // rr_ptr is 3 now: of {0,3}, 3 wins
        run_packet(4'b1001, 1, g, c);
        check("rr_after_single", g, 4'b1000);
        req = 4'b0;

        // minimum turnaround
        run_packet(4'b0001, 1, g, c);
        check("turnaround_grant", g, 4'b0001);
        check("turnaround_cycles", c, 6);
        req = 4'b0;

        // fairness from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_packet(4'b1111, 1, g, c);
            check($sformatf("fair_%0d", i), g, fair_tab[i]);
        end
        req = 4'b0;

        // spurious done from non-granted producers
        c = 0;
        req = 4'b0010;
        wait_grant(g, c);
        check("spur_grant", g, 4'b0010);
        req = 4'b0;
        wr_done = 4'b1001;
        step();
        wr_done = 4'b0;
        step();
        check("spur_hold_grant", grant, 4'b0010);
        check("spur_hold_state", st, 2);
        wr_done = 4'b0010;
        step();
        wr_done = 4'b0;
        check("spur_notify", st, 3);
        finish_send(1, c);

        // request dropped while granted
        c = 0;
        req = 4'b0001;
        wait_grant(g, c);
        req = 4'b0;
        repeat (3) step();
        check("drop_hold", grant, 4'b0001);
        wr_done = 4'b0001;
        step();
        wr_done = 4'b0;
        check("drop_release_grant", grant, 0);
        check("drop_msg", msg_stored, 1);
        finish_send(2, c);

        // reset during WAIT_SEND
        c = 0;
        req = 4'b0100;
        wait_grant(g, c);
        req = 4'b0;
        wr_done = 4'b0100;
        step();
        wr_done = 4'b0;
        busy_net = 1'b1;
        step();
        check("midrst_wait_send", st, 4);
        rst = 1'b1;
        step();
        check("midrst_grant", grant, 0);
        check("midrst_msg", msg_stored, 0);
        check("midrst_busy", busy_pp, 0);
        check("midrst_state", st, 0);
        rst = 1'b0;
        busy_net = 1'b0;
        req = 4'b0001;
        step();
        step();
        check("midrst_regrant", grant, 4'b0001);
        req = 4'b0;
        wr_done = 4'b0001;
        step();
        wr_done = 4'b0;
        finish_send(1, c);

        // producer that never finishes writing
        c = 0;
        req = 4'b0010;
        wait_grant(g, c);
        check("wd_grant", g, 4'b0010);
        req = 4'b0;
`ifdef A_TX_ARB_TIMEOUT_EN
        k = 0;
        while (grant != 4'b0 && k < 40) begin step(); k++; end
        check("wd_cycles", k, 16);
        check("wd_flag", arb_timeout, 1);
        check("wd_state", st, 5);
        req = 4'b1111;
        c = 0;
        wait_grant(g, c);
        check("wd_next_grant", g, 4'b0100);
        req = 4'b0;
        wr_done = g;
        step();
        wr_done = 4'b0;
        finish_send(1, c);
        check("wd_flag_sticky", arb_timeout, 1);
`else
        k = 0;
        repeat (100) begin step(); k++; end
        check("nowd_grant_held", grant, 4'b0010);
        check("nowd_state", st, 2);
        check("nowd_flag", arb_timeout, 0);
        check("nowd_hold_cycles", k, 100);
        wr_done = 4'b0010;
        step();
        wr_done = 4'b0;
        finish_send(1, c);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
